emu_event_timer: RTL and testbench
==================================

// Module: emu_event_timer
// PURPOSE
// - Requester side of the emulator timestep protocol: one dt_req source feeding the time manager's
//   min-reduction; consumes the granted emu_dt and emu_time.
// - Schedules periodic events in emulated time: requests dt so emulated time lands exactly on each
//   event, pulses event_out, counts events, stops after a programmed count (0 = run forever).
// PARAMETERS
// - width       32   signed width of dt_req / emu_dt / cfg_period
// - time_width  64   signed width of emu_time / event_time
// - cnt_width   16   width of cfg_count / events_done
// PORTS
// - emu_clk      in   1           emulator clock; all state on rising edge
// - emu_rst_n    in   1           reset, asynchronous assert, active-low
// - emu_dt       in   width       granted timestep (min of all dt_req) for this cycle
// - emu_time     in   time_width  emulated time before this cycle's step
// - dt_req       out  width       requested max timestep
// - cfg_valid    in   1           config offer
// - cfg_ready    out  1           config accept (cfg_valid & cfg_ready = transfer)
// - cfg_period   in   width       event period, emulated-time LSBs, signed
// - cfg_count    in   cnt_width   events to generate; 0 = unlimited
// - stop         in   1           abort schedule, return to IDLE
// - busy         out  1           high in ARMED
// - event_out    out  1           1-cycle pulse, cycle after time reaches an event
// - events_done  out  cnt_width   events fired since last accept; wraps in unlimited mode
// - event_time   out  time_width  emulated time of most recent event
// - err          out  1           sticky protocol-violation flag
// BEHAVIOUR
// - Reset (emu_rst_n=0, async): state=IDLE, remaining=0, event_out=0, events_done=0, event_time=0, err=0.
// - DT_MAX = 2^(width-1)-1. dt_req comb. from regs: ARMED -> remaining; IDLE -> DT_MAX (never limits).
// - cfg_ready = (state==IDLE) & ~stop. Accept: remaining <= max(cfg_period,1) (period<=0 clamps to 1),
//   count latched, events_done <= 0, state <= ARMED. First event one period after accept edge.
// - ARMED, each edge, evaluated in order:
//   emu_dt<0 -> err<=1, remaining held, no event.
//   emu_dt<remaining -> remaining <= remaining-emu_dt.
//   emu_dt==remaining -> fire: event_out<=1, events_done+1, remaining<=period; if count!=0 and new
//     events_done==count -> IDLE.
//   emu_dt>remaining -> err<=1, then fire as above (overshoot tolerated, not corrected).
// - stop in ARMED: state <= IDLE next edge; a fire evaluated the same edge still pulses and counts.
// - stop in IDLE: no effect; also blocks cfg accept that cycle.
// - event_out is 0 on every edge that does not fire; back-to-back pulses legal (period=1, emu_dt=1).
// - events_done wraps 2^cnt_width-1 -> 0 in unlimited mode only; holds in IDLE until next accept.
// - err cleared only by reset. All arithmetic signed; remaining never negative in legal operation.
// CONFIGURATION
// - EMU_EVENT_TIMESTAMP_EN defined: on fire, event_time <= emu_time + emu_dt (time_width, sign-extended
//   dt), i.e. emulated time after the step.
// - Not defined: event_time tied to 0; no time_width adder/register; emu_time unused.
// TESTING
// - Reset mid-ARMED (remaining=7) -> all outputs at reset values immediately, dt_req=DT_MAX.
// - period=10,count=3,emu_dt=dt_req -> dt_req 10,10,10; 3 pulses 1 cycle apart; events_done=3; IDLE.
// - period=10, emu_dt=4,4,2 (other requester smaller) -> dt_req 10,6,2; pulse after third edge; err=0.
// - period=5, emu_dt=7 -> err=1 sticky, event fires, remaining=5; later legal steps keep err=1.
// - stop on firing edge -> pulse and count increment, IDLE next cycle, cfg_ready=1 after stop low.
// - cfg_period=0 -> clamped to 1, pulse every cycle with emu_dt=1; EMU_EVENT_TIMESTAMP_EN:
//   emu_time=100 -> event_time=101.

Source files
------------

// File: rtl/emu_event_timer.sv
// Periodic emulated-time event scheduler: requests dt so emulated time lands on each event; event_out pulses the cycle after the landing edge.
// Config accepted only in IDLE without stop; EMU_EVENT_TIMESTAMP_EN adds the event_time timestamp register.
module emu_event_timer #(
   parameter int width      = 32,
   parameter int time_width = 64,
   parameter int cnt_width  = 16
) (
   input  logic                         emu_clk,
   input  logic                         emu_rst_n,
   input  logic signed [width-1:0]      emu_dt,
   input  logic signed [time_width-1:0] emu_time,
   output logic signed [width-1:0]      dt_req,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic signed [width-1:0]      cfg_period,
   input  logic [cnt_width-1:0]         cfg_count,
   input  logic                         stop,
   output logic                         busy,
   output logic                         event_out,
   output logic [cnt_width-1:0]         events_done,
   output logic signed [time_width-1:0] event_time,
   output logic                         err
);

   localparam logic signed [width-1:0] DT_MAX = {1'b0, {(width-1){1'b1}}};
   localparam logic signed [width-1:0] DT_ONE = width'(1);

   typedef enum logic {S_IDLE, S_ARMED} state_t;

   state_t                  r_state;
   logic signed [width-1:0] r_remaining;
   logic signed [width-1:0] r_period;
   logic [cnt_width-1:0]    r_count;
   logic [cnt_width-1:0]    r_events_done;
   logic                    r_event_out;
   logic                    r_err;

   logic                    w_cfg_acc;
   logic signed [width-1:0] w_period_clamped;
   logic                    w_dt_neg;
   logic                    w_dt_under;
   logic                    w_dt_over;
   logic [cnt_width-1:0]    w_done_next;

   assign w_cfg_acc        = cfg_valid & cfg_ready;
   assign w_period_clamped = (cfg_period[width-1] || (cfg_period == '0)) ? DT_ONE : cfg_period;
   assign w_dt_neg         = emu_dt[width-1];
   assign w_dt_under       = emu_dt < r_remaining;
   assign w_dt_over        = emu_dt > r_remaining;
   assign w_done_next      = r_events_done + 1'b1;

   assign dt_req      = (r_state == S_ARMED) ? r_remaining : DT_MAX;
   assign cfg_ready   = (r_state == S_IDLE) & ~stop;
   assign busy        = (r_state == S_ARMED);
   assign event_out   = r_event_out;
   assign events_done = r_events_done;
   assign err         = r_err;

   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n) begin
         r_state       <= S_IDLE;
         r_remaining   <= '0;
         r_period      <= '0;
         r_count       <= '0;
         r_events_done <= '0;
         r_event_out   <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_event_out <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_cfg_acc) begin
                  r_remaining   <= w_period_clamped;
                  r_period      <= w_period_clamped;
                  r_count       <= cfg_count;
                  r_events_done <= '0;
                  r_state       <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (w_dt_neg) begin
                  r_err <= 1'b1;
               end else if (w_dt_under) begin
                  r_remaining <= r_remaining - emu_dt;
               end else begin
                  // Overshoot is flagged but still fires; the schedule is not re-aligned.
                  if (w_dt_over)
                     r_err <= 1'b1;
                  r_event_out   <= 1'b1;
                  r_events_done <= w_done_next;
                  r_remaining   <= r_period;
                  if ((r_count != '0) && (w_done_next == r_count))
                     r_state <= S_IDLE;
               end
               if (stop)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef EMU_EVENT_TIMESTAMP_EN
   logic signed [time_width-1:0] r_event_time;
   logic signed [time_width-1:0] w_dt_ext;

   assign w_dt_ext   = {{(time_width-width){emu_dt[width-1]}}, emu_dt};
   assign event_time = r_event_time;

   always_ff @(posedge emu_clk or negedge emu_rst_n) begin
      if (!emu_rst_n)
         r_event_time <= '0;
      else if ((r_state == S_ARMED) && !w_dt_neg && !w_dt_under)
         r_event_time <= emu_time + w_dt_ext;
   end
`else
   logic w_unused_time;

   assign w_unused_time = ^emu_time;
   assign event_time    = '0;
`endif

endmodule

// File: tb/tb_emu_event_timer.sv
// Directed bench for emu_event_timer: reset, periodic schedule, partial steps, overshoot, stop, clamp.
module tb_emu_event_timer;
   localparam int W  = 32;
   localparam int TW = 64;
   localparam int CW = 16;
   localparam logic [63:0] DTMAX = 64'h0000_0000_7FFF_FFFF;

   logic                  emu_clk = 1'b0;
   logic                  emu_rst_n;
   logic signed [W-1:0]   emu_dt;
   logic signed [TW-1:0]  emu_time;
   logic signed [W-1:0]   dt_req;
   logic                  cfg_valid;
   logic                  cfg_ready;
   logic signed [W-1:0]   cfg_period;
   logic [CW-1:0]         cfg_count;
   logic                  stop;
   logic                  busy;
   logic                  event_out;
   logic [CW-1:0]         events_done;
   logic signed [TW-1:0]  event_time;
   logic                  err;

   int n_tests = 0;
   int n_fail  = 0;

   emu_event_timer #(.width(W), .time_width(TW), .cnt_width(CW)) dut (
      .emu_clk     (emu_clk),
      .emu_rst_n   (emu_rst_n),
      .emu_dt      (emu_dt),
      .emu_time    (emu_time),
      .dt_req      (dt_req),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_period  (cfg_period),
      .cfg_count   (cfg_count),
      .stop        (stop),
      .busy        (busy),
      .event_out   (event_out),
      .events_done (events_done),
      .event_time  (event_time),
      .err         (err)
   );

   always #5 emu_clk = ~emu_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge emu_clk);
      #1;
   endtask

   initial begin
      emu_rst_n  = 1'b0;
      emu_dt     = '0;
      emu_time   = '0;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_count  = '0;
      stop       = 1'b0;
      #3;
      chk("rst_dt_req", dt_req, DTMAX);
      chk("rst_busy", busy, 0);
      chk("rst_event_out", event_out, 0);
      chk("rst_events_done", events_done, 0);
      chk("rst_event_time", event_time, 0);
      chk("rst_err", err, 0);
      chk("rst_cfg_ready", cfg_ready, 1);
      emu_rst_n = 1'b1;

      // Reset while ARMED with remaining=7.
      cfg_valid = 1'b1; cfg_period = 10; cfg_count = 0;
      tick();
      cfg_valid = 1'b0;
      chk("armA_busy", busy, 1);
      chk("armA_dt_req", dt_req, 10);
      chk("armA_cfg_ready", cfg_ready, 0);
      emu_dt = 3;
      tick();
      chk("armA_rem7", dt_req, 7);
      #2 emu_rst_n = 1'b0;
      #1;
      chk("midrst_dt_req", dt_req, DTMAX);
      chk("midrst_busy", busy, 0);
      chk("midrst_event_out", event_out, 0);
      chk("midrst_events_done", events_done, 0);
      chk("midrst_err", err, 0);
      emu_rst_n = 1'b1;

      // period=10, count=3, requester alone.
      cfg_valid = 1'b1; cfg_period = 10; cfg_count = 3;
      tick();
      cfg_valid = 1'b0;
      chk("B_evt_after_acc", event_out, 0);
      for (int i = 0; i < 3; i++) begin
         chk("B_dt_req", dt_req, 10);
         emu_dt = 10;
         tick();
         chk("B_pulse", event_out, 1);
         chk("B_events_done", events_done, 64'(i + 1));
      end
      chk("B_idle", busy, 0);
      chk("B_dt_req_idle", dt_req, DTMAX);
      chk("B_err", err, 0);
      emu_dt = 0;
      tick();
      chk("B_no_pulse", event_out, 0);
      chk("B_done_hold", events_done, 3);

      // period=10 with a smaller competing requester.
      cfg_valid = 1'b1; cfg_period = 10; cfg_count = 0;
      tick();
      cfg_valid = 1'b0;
      chk("C_events_reset", events_done, 0);
      chk("C_dt0", dt_req, 10);
      emu_dt = 4; tick();
      chk("C_dt1", dt_req, 6);
      chk("C_nopulse1", event_out, 0);
      emu_dt = 4; tick();
      chk("C_dt2", dt_req, 2);
      chk("C_nopulse2", event_out, 0);
      emu_dt = 2; tick();
      chk("C_pulse", event_out, 1);
      chk("C_reload", dt_req, 10);
      chk("C_err", err, 0);
      chk("C_done", events_done, 1);

      // stop on the firing edge.
      emu_dt = 10; stop = 1'b1;
      tick();
      chk("S_pulse", event_out, 1);
      chk("S_done", events_done, 2);
      chk("S_idle", busy, 0);
      chk("S_ready_blocked", cfg_ready, 0);
      cfg_valid = 1'b1; cfg_period = 5;
      tick();
      chk("S_no_accept", busy, 0);
      chk("S_done_hold", events_done, 2);
      stop = 1'b0;
      #1;
      chk("S_ready", cfg_ready, 1);

      // period=5 overshoot with emu_dt=7.
      tick();
      cfg_valid = 1'b0;
      chk("D_armed", busy, 1);
      chk("D_events_reset", events_done, 0);
      emu_dt = 7; tick();
      chk("D_err", err, 1);
      chk("D_pulse", event_out, 1);
      chk("D_reload", dt_req, 5);
      chk("D_done", events_done, 1);
      emu_dt = 5; tick();
      chk("D_pulse2", event_out, 1);
      chk("D_err_sticky", err, 1);
      emu_dt = 2; tick();
      chk("D_dt", dt_req, 3);
      chk("D_nopulse", event_out, 0);
      emu_dt = -1; tick();
      chk("D_neg_hold", dt_req, 3);
      chk("D_neg_nopulse", event_out, 0);
      chk("D_neg_err", err, 1);
      stop = 1'b1; emu_dt = 0; tick();
      stop = 1'b0;
      chk("D_stopped", busy, 0);

      // period=0 clamps to 1; back-to-back pulses.
      cfg_valid = 1'b1; cfg_period = 0; cfg_count = 0;
      tick();
      cfg_valid = 1'b0;
      chk("E_clamp", dt_req, 1);
      emu_dt = 1; emu_time = 100;
      tick();
      chk("E_pulse1", event_out, 1);
`ifdef EMU_EVENT_TIMESTAMP_EN
      chk("E_time1", event_time, 101);
`else
      chk("E_time_tied", event_time, 0);
`endif
      emu_time = 101;
      tick();
      chk("E_pulse2", event_out, 1);
      chk("E_done2", events_done, 2);
`ifdef EMU_EVENT_TIMESTAMP_EN
      chk("E_time2", event_time, 102);
`endif
      stop = 1'b1; tick();
      stop = 1'b0;
      cfg_valid = 1'b1; cfg_period = -5; cfg_count = 1;
      tick();
      cfg_valid = 1'b0;
      chk("E_neg_clamp", dt_req, 1);
      emu_dt = 1; tick();
      chk("E_count1_pulse", event_out, 1);
      chk("E_count1_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
